pkt_fifo_writer: RTL and testbench

Ingress packet assembler that sits directly upstream of the packet FIFO in the custom router. It accepts a byte stream with a valid/ready handshake and parses the router packet format: source_id, dest_id, size, `size` data bytes, then crc. It writes each word into the FIFO's current write slot by word address and pulses `winc` to commit the slot only when the size and CRC checks pass. Rejected packets are never committed and are counted.

---
 rtl/router_pkg.sv | 38 +++
 rtl/pkt_fifo_writer_if.sv | 29 ++
 rtl/pkt_crc_acc.sv | 24 ++
 rtl/pkt_fifo_writer.sv | 143 ++++++++++++++
 tb/tb_pkt_fifo_writer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: writer FSM states, packet field offsets and helpers.
package router_pkg;

    localparam int unsigned OFF_SRC       = 0;
    localparam int unsigned OFF_DST       = 1;
    localparam int unsigned OFF_SIZE      = 2;
    localparam int unsigned OFF_DATA      = 3;
    localparam int unsigned HDR_TRL_WORDS = 4;
    localparam int unsigned DROP_CNT_W    = 8;
    localparam int unsigned BYTE_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DST  = 3'd1,
        ST_SIZE = 3'd2,
        ST_DATA = 3'd3,
        ST_CRC  = 3'd4,
        ST_DROP = 3'd5,
        ST_GAP  = 3'd6
    } wr_state_e;

    // Largest payload a slot can hold: header (3 words) and crc take the rest.
    function automatic int unsigned max_data(input int unsigned width);
        return width - HDR_TRL_WORDS;
    endfunction

    // One step of the byte-wise XOR fold used as the packet check value.
    function automatic logic [BYTE_W-1:0] crc_fold(input logic [BYTE_W-1:0] acc,
                                                   input logic [BYTE_W-1:0] b);
        return acc ^ b;
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pkt_fifo_writer_if.sv
// Byte-stream ingress and FIFO write-side signals of the packet writer.
interface pkt_fifo_writer_if #(
    parameter int unsigned UWIDTH    = 8,
    parameter int unsigned PTR_IN_SZ = 4
) ();

    logic [UWIDTH-1:0]                   in_data;
    logic                                in_valid;
    logic                                in_ready;
    logic                                wfull;
    logic [PTR_IN_SZ-1:0]                waddr_in;
    logic [UWIDTH-1:0]                   wdata;
    logic                                winc;
    logic                                pkt_ok;
    logic                                crc_err;
    logic                                size_err;
    logic [router_pkg::DROP_CNT_W-1:0]   drop_cnt;

    modport master (
        output in_data, in_valid, wfull,
        input  in_ready, waddr_in, wdata, winc, pkt_ok, crc_err, size_err, drop_cnt
    );

    modport slave (
        input  in_data, in_valid, wfull,
        output in_ready, waddr_in, wdata, winc, pkt_ok, crc_err, size_err, drop_cnt
    );

endinterface

// File: rtl/pkt_crc_acc.sv
// Running XOR check accumulator; shared with the egress checker.
module pkt_crc_acc #(
    parameter int unsigned UWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [UWIDTH-1:0] din,
    output logic [UWIDTH-1:0] acc
);

    // clr together with en restarts the fold at din (first byte of a packet).
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= (clr ? '0 : acc) ^ din;
        end else if (clr) begin
            acc <= '0;
        end
    end

endmodule

// File: rtl/pkt_fifo_writer.sv
// Ingress packet assembler: parses src/dst/size/data/crc and commits good packets to the FIFO slot.
module pkt_fifo_writer
    import router_pkg::*;
#(
    parameter int unsigned UWIDTH    = 8,
    parameter int unsigned WIDTH     = 11,
    parameter int unsigned PTR_IN_SZ = 4
) (
    input logic              clk1,
    input logic              rst,
    pkt_fifo_writer_if.slave bus
);

    localparam int unsigned MAXDATA = max_data(WIDTH);
    localparam int unsigned CNT_W   = UWIDTH + 1;

    wr_state_e             state;
    logic [CNT_W-1:0]      cnt;
    logic [PTR_IN_SZ-1:0]  waddr_q;
    logic [UWIDTH-1:0]     wdata_q;
    logic [UWIDTH-1:0]     crc_acc;
    logic                  winc_q;
    logic                  pkt_ok_q;
    logic                  crc_err_q;
    logic                  size_err_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic                  in_ready_c;
    logic                  accept;
    logic                  size_ok;
    logic                  crc_clr;
    logic                  crc_en;

    // Ready depends only on state; wfull gates nothing but the start of a packet.
    always_comb begin
        in_ready_c = 1'b1;
        case (state)
            ST_IDLE: in_ready_c = ~bus.wfull;
            ST_GAP:  in_ready_c = 1'b0;
            default: ;
        endcase
    end

    assign accept  = bus.in_valid & in_ready_c;
    assign size_ok = (bus.in_data != '0) && (32'(bus.in_data) <= MAXDATA);
    assign crc_clr = accept && (state == ST_IDLE);
    assign crc_en  = accept && (state inside {ST_IDLE, ST_DST, ST_SIZE, ST_DATA});

    pkt_crc_acc #(.UWIDTH(UWIDTH)) u_crc (
        .clk (clk1),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (bus.in_data),
        .acc (crc_acc)
    );

    // Packet parser FSM with registered slot writes and status pulses.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            winc_q     <= 1'b0;
            pkt_ok_q   <= 1'b0;
            crc_err_q  <= 1'b0;
            size_err_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            winc_q     <= 1'b0;
            pkt_ok_q   <= 1'b0;
            crc_err_q  <= 1'b0;
            size_err_q <= 1'b0;
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        waddr_q <= PTR_IN_SZ'(OFF_SRC);
                        wdata_q <= bus.in_data;
                        state   <= ST_DST;
                    end
                    ST_DST: begin
                        waddr_q <= PTR_IN_SZ'(OFF_DST);
                        wdata_q <= bus.in_data;
                        state   <= ST_SIZE;
                    end
                    ST_SIZE: begin
                        waddr_q <= PTR_IN_SZ'(OFF_SIZE);
                        wdata_q <= bus.in_data;
                        if (size_ok) begin
                            cnt   <= CNT_W'(bus.in_data);
                            state <= ST_DATA;
                        end else begin
                            // Skip the claimed payload plus its crc byte.
                            cnt        <= CNT_W'(bus.in_data) + CNT_W'(1);
                            size_err_q <= 1'b1;
                            state      <= ST_DROP;
                        end
                    end
                    ST_DATA: begin
                        waddr_q <= waddr_q + PTR_IN_SZ'(1);
                        wdata_q <= bus.in_data;
                        cnt     <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_CRC;
                        end
                    end
                    ST_CRC: begin
                        waddr_q <= waddr_q + PTR_IN_SZ'(1);
                        wdata_q <= bus.in_data;
                        if (bus.in_data == crc_acc) begin
                            winc_q   <= 1'b1;
                            pkt_ok_q <= 1'b1;
                        end else begin
                            crc_err_q  <= 1'b1;
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                        end
                        state <= ST_GAP;
                    end
                    ST_DROP: begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                            state      <= ST_GAP;
                        end
                    end
                    default: ;
                endcase
            end else if (state == ST_GAP) begin
                state <= ST_IDLE;
            end
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.waddr_in = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.winc     = winc_q;
    assign bus.pkt_ok   = pkt_ok_q;
    assign bus.crc_err  = crc_err_q;
    assign bus.size_err = size_err_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pkt_fifo_writer.sv
// Self-checking bench for pkt_fifo_writer: directed packets plus randomized traffic against a packet-level model.
module tb_pkt_fifo_writer;

    localparam int unsigned UW   = 8;
    localparam int unsigned WD   = 11;
    localparam int unsigned PW   = 4;
    localparam int          MAXD = 7;

    typedef logic [7:0] bq_t[$];

    logic       clk1;
    logic       rst;
    int         checks = 0;
    int         errors = 0;
    logic [PW-1:0] m_addr;
    logic [7:0] m_data;
    logic [7:0] m_drop;
    bit         gap_pending;

    pkt_fifo_writer_if #(.UWIDTH(UW), .PTR_IN_SZ(PW)) bus ();

    pkt_fifo_writer #(.UWIDTH(UW), .WIDTH(WD), .PTR_IN_SZ(PW)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pulses();
        return {bus.winc, bus.pkt_ok, bus.crc_err, bus.size_err};
    endfunction

    // Packet = src, dst, size, size data bytes, check byte (correct or corrupted).
    function automatic bq_t make_pkt(input logic [7:0] src, input logic [7:0] dst,
                                     input logic [7:0] size, input bit crc_ok);
        bq_t        q;
        logic [7:0] x;
        logic [7:0] d;
        q.push_back(src);
        q.push_back(dst);
        q.push_back(size);
        x = src ^ dst ^ size;
        for (int i = 0; i < int'(size); i++) begin
            d = 8'($urandom);
            q.push_back(d);
            x = x ^ d;
        end
        if (crc_ok) q.push_back(x);
        else        q.push_back(x ^ 8'($urandom_range(1, 255)));
        return q;
    endfunction

    task automatic check_hold(input string tag);
        chk({tag, "_waddr"},  32'(bus.waddr_in), 32'(m_addr));
        chk({tag, "_wdata"},  32'(bus.wdata),    32'(m_data));
        chk({tag, "_pulses"}, 32'(pulses()),     32'(0));
        chk({tag, "_drop"},   32'(bus.drop_cnt), 32'(m_drop));
    endtask

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(posedge clk1);
        #1;
        gap_pending = 1'b0;
        check_hold("idle");
    endtask

    // Offer one byte and hold it until accepted; reports how many cycles it stalled.
    task automatic push(input logic [7:0] b, output int waited);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        waited = 0;
        @(negedge clk1);
        while (!bus.in_ready && waited < 20) begin
            waited++;
            @(negedge clk1);
            chk("stall_pulses", 32'(pulses()), 32'(0));
        end
        if (!bus.in_ready) chk("ready_timeout", 32'(bus.in_ready), 32'(1));
        @(posedge clk1);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    // Send a packet (or its first stop_at bytes) and check each accepted byte against the model.
    task automatic send_pkt(input bq_t p, input bit wfull_mid, input bit bubbles, input int stop_at);
        int         sz;
        int         n;
        int         waited;
        bit         size_good;
        bit         crc_good;
        bit         last;
        logic [7:0] x;
        sz = int'(p[2]);
        size_good = (sz >= 1) && (sz <= MAXD);
        x = 8'd0;
        for (int i = 0; i < 3 + sz; i++) x = x ^ p[i];
        crc_good = size_good && (p[3 + sz] == x);
        n = (stop_at >= 0) ? stop_at : p.size();
        for (int j = 0; j < n; j++) begin
            if (bubbles && j > 0 && $urandom_range(0, 3) == 0) idle_cycle();
            push(p[j], waited);
            if (j == 0) chk("first_wait", 32'(waited), gap_pending ? 32'(1) : 32'(0));
            else        chk("byte_wait",  32'(waited), 32'(0));
            gap_pending = 1'b0;
            if (j == 0 && wfull_mid) bus.wfull = 1'b1;
            last = (j == p.size() - 1);
            if (size_good || j < 3) begin
                m_addr = PW'(j);
                m_data = p[j];
            end
            if (last && !crc_good) m_drop = (m_drop == 8'hFF) ? m_drop : m_drop + 8'd1;
            chk("waddr_in", 32'(bus.waddr_in), 32'(m_addr));
            chk("wdata",    32'(bus.wdata),    32'(m_data));
            chk("winc",     32'(bus.winc),     32'(last && crc_good));
            chk("pkt_ok",   32'(bus.pkt_ok),   32'(last && crc_good));
            chk("crc_err",  32'(bus.crc_err),  32'(last && size_good && !crc_good));
            chk("size_err", 32'(bus.size_err), 32'(j == 2 && !size_good));
            chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
        end
        if (n == p.size()) gap_pending = 1'b1;
        bus.wfull = 1'b0;
    endtask

    initial begin
        bq_t p;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        bus.wfull    = 1'b0;
        m_addr       = '0;
        m_data       = 8'd0;
        m_drop       = 8'd0;
        gap_pending  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk1);
        #1;
        check_hold("reset");
        rst = 1'b0;
        @(posedge clk1);
        #1;
        chk("idle_ready", 32'(bus.in_ready), 32'(1));

        // Good packet, then a back-to-back good packet (one GAP stall expected)
        p = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd170};
        send_pkt(p, 1'b0, 1'b0, -1);
        p = '{8'd100, 8'd10, 8'd4, 8'd0, 8'd1, 8'd2, 8'd3, 8'd106};
        send_pkt(p, 1'b0, 1'b0, -1);

        // Bad check byte
        p = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};
        send_pkt(p, 1'b0, 1'b0, -1);

        // Oversized and zero size
        send_pkt(make_pkt(8'd5, 8'd6, 8'd9, 1'b1), 1'b0, 1'b0, -1);
        send_pkt(make_pkt(8'd5, 8'd6, 8'd0, 1'b1), 1'b0, 1'b0, -1);
        send_pkt(make_pkt(8'd1, 8'd2, 8'd7, 1'b1), 1'b0, 1'b0, -1);
        send_pkt(make_pkt(8'd1, 8'd2, 8'd8, 1'b1), 1'b0, 1'b0, -1);

        // FIFO full while idle blocks the source byte; wfull mid-packet does not stall
        idle_cycle();
        p = make_pkt(8'd7, 8'd9, 8'd5, 1'b1);
        bus.wfull    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = p[0];
        repeat (3) begin
            @(posedge clk1);
            #1;
            chk("wfull_ready", 32'(bus.in_ready), 32'(0));
            check_hold("wfull");
        end
        bus.wfull = 1'b0;
        #1;
        chk("wfull_release_ready", 32'(bus.in_ready), 32'(1));
        send_pkt(p, 1'b1, 1'b0, -1);

        // Reset after dest_id abandons the packet
        idle_cycle();
        p = make_pkt(8'd33, 8'd44, 8'd2, 1'b1);
        send_pkt(p, 1'b0, 1'b0, 2);
        rst = 1'b1;
        @(posedge clk1);
        #1;
        rst = 1'b0;
        m_addr      = '0;
        m_data      = 8'd0;
        m_drop      = 8'd0;
        gap_pending = 1'b0;
        check_hold("midreset");
        chk("midreset_ready", 32'(bus.in_ready), 32'(1));
        idle_cycle();
        send_pkt(make_pkt(8'd50, 8'd60, 8'd6, 1'b1), 1'b0, 1'b0, -1);

        // Largest size byte drops 256 bytes after it
        send_pkt(make_pkt(8'd3, 8'd4, 8'd255, 1'b1), 1'b0, 1'b0, -1);

        // Randomized traffic with bubbles, idle gaps and mid-packet wfull
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) idle_cycle();
            send_pkt(make_pkt(8'($urandom), 8'($urandom), 8'($urandom_range(0, 10)),
                              $urandom_range(0, 3) != 0),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, -1);
        end

        // Drop counter saturation
        for (int k = 0; k < 260; k++) begin
            send_pkt(make_pkt(8'($urandom), 8'($urandom), 8'd0, 1'b1), 1'b0, 1'b0, -1);
        end
        chk("drop_sat", 32'(bus.drop_cnt), 32'(255));
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
